// File: rtl/config_initiator.sv
// Builds LArPix config packets for the tx UART and collects read responses.
// Optional feature macro: CFG_PARITY_CHECK_EN (response parity checking).
module config_initiator #(
    parameter int WIDTH          = 64,
    parameter int GLOBAL_ID      = 255,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_read,
    input  logic [7:0]       cmd_chip_id,
    input  logic [7:0]       cmd_addr,
    input  logic [7:0]       cmd_data,
    output logic [WIDTH-1:0] tx_data,
    output logic             ld_tx_data,
    input  logic             tx_busy,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_data_flag,
    output logic             resp_valid,
    output logic [7:0]       resp_data,
    output logic [7:0]       resp_chip_id,
    output logic             resp_parity_err,
    output logic [7:0]       resp_count,
    output logic             done,
    output logic             timeout_err,
    output logic             busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [1:0]    CONFIG_WRITE_OP = 2'b10;
    localparam logic [1:0]    CONFIG_READ_OP  = 2'b11;
    localparam logic [31:0]   MAGIC_NUMBER    = 32'h8950_4e47;
    localparam logic [7:0]    GID             = 8'(GLOBAL_ID);
    localparam logic [TW-1:0] START_LAST      = TW'(14);
    localparam logic [TW-1:0] TIMER_LAST      = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        BUILD,
        LOAD_TX,
        WAIT_TX_START,
        WAIT_TX_DONE,
        WAIT_RESP,
        DONE,
        FINISH
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          rd_q;
    logic          glob_q;
    logic [7:0]    chip_q;
    logic [7:0]    addr_q;
    logic          to_q;

    logic rx_match;
    logic par_ok;
    logic expired;

    function automatic logic [WIDTH-1:0] build_pkt(
        input logic       rd,
        input logic [7:0] chip,
        input logic [7:0] addr,
        input logic [7:0] data
    );
        logic [WIDTH-1:0] p;
        p          = '0;
        p[1:0]     = rd ? CONFIG_READ_OP : CONFIG_WRITE_OP;
        p[9:2]     = chip;
        p[17:10]   = addr;
        p[25:18]   = rd ? 8'h00 : data;
        p[57:26]   = MAGIC_NUMBER;
        p[WIDTH-1] = ~^p[WIDTH-2:0];
        return p;
    endfunction

`ifdef CFG_PARITY_CHECK_EN
    assign par_ok = ^rx_data;
`else
    logic unused_rx;
    assign unused_rx = ^{rx_data[WIDTH-1], rx_data[61:26]};
    assign par_ok    = 1'b1;
`endif

    assign rx_match = rx_data_flag
                   && rx_data[1:0] == CONFIG_READ_OP
                   && rx_data[62]
                   && rx_data[17:10] == addr_q
                   && (glob_q || rx_data[9:2] == chip_q);

    assign expired = timer == TIMER_LAST;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            timer           <= '0;
            rd_q            <= 1'b0;
            glob_q          <= 1'b0;
            chip_q          <= '0;
            addr_q          <= '0;
            to_q            <= 1'b0;
            cmd_ready       <= 1'b1;
            tx_data         <= '0;
            ld_tx_data      <= 1'b0;
            resp_valid      <= 1'b0;
            resp_data       <= '0;
            resp_chip_id    <= '0;
            resp_parity_err <= 1'b0;
            resp_count      <= '0;
            done            <= 1'b0;
            timeout_err     <= 1'b0;
            busy            <= 1'b0;
        end else begin
            ld_tx_data      <= 1'b0;
            resp_valid      <= 1'b0;
            resp_parity_err <= 1'b0;
            done            <= 1'b0;
            timeout_err     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        rd_q       <= cmd_read;
                        glob_q     <= cmd_chip_id == GID;
                        chip_q     <= cmd_chip_id;
                        addr_q     <= cmd_addr;
                        resp_count <= '0;
                        tx_data    <= build_pkt(cmd_read, cmd_chip_id,
                                                cmd_addr, cmd_data);
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= BUILD;
                    end
                end
                BUILD: begin
                    if (!tx_busy) begin
                        ld_tx_data <= 1'b1;
                        state      <= LOAD_TX;
                    end
                end
                LOAD_TX: begin
                    timer <= '0;
                    state <= WAIT_TX_START;
                end
                // Fall through if the UART never reports busy.
                WAIT_TX_START: begin
                    if (tx_busy || timer == START_LAST) begin
                        state <= WAIT_TX_DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_TX_DONE: begin
                    if (!tx_busy) begin
                        timer <= '0;
                        to_q  <= 1'b0;
                        state <= rd_q ? WAIT_RESP : DONE;
                    end
                end
                WAIT_RESP: begin
                    timer <= timer + 1'b1;
                    if (rx_match) begin
                        resp_valid      <= 1'b1;
                        resp_data       <= rx_data[25:18];
                        resp_chip_id    <= rx_data[9:2];
                        resp_parity_err <= !par_ok;
                        if (resp_count != 8'hff) begin
                            resp_count <= resp_count + 1'b1;
                        end
                    end
                    // A match in the expiry cycle still wins.
                    if (rx_match && par_ok && !glob_q) begin
                        to_q  <= 1'b0;
                        state <= DONE;
                    end else if (expired) begin
                        to_q  <= glob_q ? (resp_count == '0 && !rx_match)
                                        : 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done        <= 1'b1;
                    timeout_err <= to_q;
                    state       <= FINISH;
                end
                FINISH: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_config_initiator.sv
// Self-checking bench for config_initiator: hand vectors plus random
// commands checked against a response-window reference model.
module tb_config_initiator;

    localparam int T = 64;

    localparam logic [1:0]  WR_OP = 2'b10;
    localparam logic [1:0]  RD_OP = 2'b11;
    localparam logic [31:0] MAGIC = 32'h8950_4e47;

`ifdef CFG_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic [7:0]  cmd_chip_id;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic [63:0] tx_data;
    logic        ld_tx_data;
    logic        tx_busy;
    logic [63:0] rx_data;
    logic        rx_data_flag;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic [7:0]  resp_chip_id;
    logic        resp_parity_err;
    logic [7:0]  resp_count;
    logic        done;
    logic        timeout_err;
    logic        busy;

    config_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_read        (cmd_read),
        .cmd_chip_id     (cmd_chip_id),
        .cmd_addr        (cmd_addr),
        .cmd_data        (cmd_data),
        .tx_data         (tx_data),
        .ld_tx_data      (ld_tx_data),
        .tx_busy         (tx_busy),
        .rx_data         (rx_data),
        .rx_data_flag    (rx_data_flag),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_chip_id    (resp_chip_id),
        .resp_parity_err (resp_parity_err),
        .resp_count      (resp_count),
        .done            (done),
        .timeout_err     (timeout_err),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Response offsets k are biased by 16; k is counted from the
    // response-window entry, and exp_done is 0 when no done is expected.
    typedef struct packed {
        logic             rd;
        logic [7:0]       chip;
        logic [7:0]       addr;
        logic [7:0]       data;
        logic [7:0]       hold;
        logic [7:0]       tlen;
        logic [7:0]       abort_kb;
        logic [2:0]       nr;
        logic [3:0][7:0]  kb;
        logic [3:0][63:0] pkt;
        logic [3:0]       hit;
        logic [7:0]       exp_n;
        logic             exp_to;
        logic [7:0]       exp_done;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] cmd_pkt(input logic rd,
        input logic [7:0] chip, input logic [7:0] addr,
        input logic [7:0] data);
        logic [63:0] p;
        p = {1'b0, 5'b0, MAGIC, rd ? 8'h00 : data, addr, chip,
             rd ? RD_OP : WR_OP};
        p[63] = ~^p[62:0];
        return p;
    endfunction

    function automatic logic [63:0] rsp_pkt(input logic [7:0] chip,
        input logic [7:0] addr, input logic [7:0] data,
        input logic [1:0] op, input logic b62, input logic good);
        logic [63:0] p;
        p = {1'b0, b62, 4'b0, MAGIC, data, addr, chip, op};
        p[63] = good ? ~^p[62:0] : ^p[62:0];
        return p;
    endfunction

    function automatic vec_t mkv(input logic rd, input logic [7:0] chip,
        input logic [7:0] addr, input logic [7:0] data,
        input logic [7:0] hold, input logic [7:0] tlen);
        vec_t v;
        v      = '0;
        v.rd   = rd;
        v.chip = chip;
        v.addr = addr;
        v.data = data;
        v.hold = hold;
        v.tlen = tlen;
        return v;
    endfunction

    // Reference: walk the scheduled responses in time order inside the
    // window [0, T-1]; a good unicast match ends the window early.
    function automatic vec_t model(input vec_t v);
        int  n;
        int  dn;
        int  k;
        bit  glob;
        bit  m;
        logic [63:0] p;
        v.hit    = '0;
        v.exp_to = 1'b0;
        n        = 0;
        if (!v.rd) begin
            v.exp_done = 8'd1;
            v.exp_n    = 8'd0;
            return v;
        end
        glob = v.chip == 8'hff;
        dn   = T + 1;
        for (int i = 0; i < 4; i++) begin
            if (i >= int'(v.nr)) break;
            k = int'(v.kb[i]) - 16;
            p = v.pkt[i];
            if (k < 0 || k > T - 1) continue;
            m = p[1:0] == RD_OP && p[62] && p[17:10] == v.addr
                && (glob || p[9:2] == v.chip);
            if (!m) continue;
            v.hit[i] = 1'b1;
            n++;
            if (!glob && (!PCHK || (^p))) begin
                dn = k + 2;
                break;
            end
        end
        if (dn == T + 1) v.exp_to = glob ? (n == 0) : 1'b1;
        v.exp_done = 8'(dn);
        v.exp_n    = 8'(n);
        return v;
    endfunction

    task automatic check_reset(input string nm);
        check({nm, ".rstvals"},
              {tx_data[62:0], ld_tx_data, resp_valid, resp_parity_err},
              {63'd0, 3'b000});
        check({nm, ".rstvals2"},
              {tx_data[63], done, timeout_err, busy, cmd_ready,
               resp_data, resp_chip_id, resp_count},
              {5'b00001, 24'd0});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic run(input vec_t v, input string nm);
        logic [63:0] ep;
        int ld_at;
        int d;
        int k;
        int ri;
        int hi;
        int nresp;
        int done_at;
        int extra_ld;
        bit stable;
        bit to_seen;
        bit dn_bad;
        ep       = cmd_pkt(v.rd, v.chip, v.addr, v.data);
        ld_at    = -1;
        hi       = 0;
        nresp    = 0;
        done_at  = 0;
        extra_ld = 0;
        stable   = 1'b1;
        to_seen  = 1'b0;
        check({nm, ".ready"}, cmd_ready, 1'b1);
        tx_busy      = v.hold != 0;
        rx_data_flag = 1'b0;
        cmd_valid    = 1'b1;
        cmd_read     = v.rd;
        cmd_chip_id  = v.chip;
        cmd_addr     = v.addr;
        cmd_data     = v.data;
        tick();
        cmd_valid   = 1'b0;
        cmd_read    = 1'($urandom);
        cmd_chip_id = 8'($urandom);
        cmd_addr    = 8'($urandom);
        cmd_data    = 8'($urandom);
        check({nm, ".busy"}, {busy, cmd_ready}, 2'b10);
        for (int i = 1; i <= int'(v.hold) + 40; i++) begin
            tick();
            if (ld_tx_data) begin
                ld_at = i;
                break;
            end
            if (i == int'(v.hold)) tx_busy = 1'b0;
        end
        check({nm, ".ld_lat"}, 64'(ld_at), 64'(int'(v.hold) + 1));
        if (ld_at < 0) begin
            tx_busy = 1'b0;
            do_reset();
            return;
        end
        check({nm, ".tx_data"}, tx_data, ep);
        d = (v.tlen == 0) ? 17 : int'(v.tlen) + 1;
        for (int j = 1; j <= d + T + 8; j++) begin
            tx_busy      = j <= int'(v.tlen);
            k            = j - d - 1;
            ri           = -1;
            rx_data_flag = 1'b0;
            rx_data      = {$urandom, $urandom} & ~(64'd1 << 62);
            for (int i = 0; i < 4; i++)
                if (i < int'(v.nr) && int'(v.kb[i]) - 16 == k) ri = i;
            if (ri >= 0) begin
                rx_data      = v.pkt[ri];
                rx_data_flag = 1'b1;
            end else if ($urandom_range(0, 7) == 0) begin
                rx_data_flag = 1'b1;
            end
            if (v.abort_kb != 0 && k == int'(v.abort_kb) - 16) begin
                reset_n = 1'b0;
                #1;
                check_reset({nm, ".abort"});
                tick();
                tick();
                reset_n      = 1'b1;
                rx_data_flag = 1'b0;
                tx_busy      = 1'b0;
                dn_bad       = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    tick();
                    if (done) dn_bad = 1'b1;
                end
                check({nm, ".no_done"}, dn_bad, 1'b0);
                check({nm, ".ready_after"}, cmd_ready, 1'b1);
                return;
            end
            tick();
            if (ld_tx_data) extra_ld++;
            if (tx_data !== ep) stable = 1'b0;
            if (resp_valid) begin
                nresp++;
                while (hi < 4 && !v.hit[hi]) hi++;
                if (hi < 4) begin
                    check({nm, ".rsp_k"}, 64'(k),
                          64'(int'(v.kb[hi]) - 16));
                    check({nm, ".rsp_data"}, resp_data,
                          v.pkt[hi][25:18]);
                    check({nm, ".rsp_chip"}, resp_chip_id,
                          v.pkt[hi][9:2]);
                    check({nm, ".rsp_perr"}, resp_parity_err,
                          PCHK && !(^v.pkt[hi]));
                    hi++;
                end else begin
                    check({nm, ".rsp_extra"}, 1'b1, 1'b0);
                end
            end
            if (done) begin
                done_at = j - d;
                to_seen = timeout_err;
                check({nm, ".ready_in_done"}, cmd_ready, 1'b0);
                tick();
                check({nm, ".ready_after"}, {cmd_ready, busy}, 2'b10);
                break;
            end
        end
        rx_data_flag = 1'b0;
        tx_busy      = 1'b0;
        check({nm, ".done_off"}, 64'(done_at), 64'(v.exp_done));
        check({nm, ".timeout"}, to_seen, v.exp_to);
        check({nm, ".nresp"}, 64'(nresp), 64'(v.exp_n));
        check({nm, ".count"}, resp_count, v.exp_n);
        check({nm, ".one_ld"}, 64'(extra_ld), 64'd0);
        check({nm, ".stable"}, stable, 1'b1);
        if (done_at == 0) do_reset();
    endtask

    vec_t tbl[10];
    vec_t rv;

    initial begin
        int k;
        int n;
        bit g;
        logic [7:0] c;
        logic [7:0] a;

        tbl[0] = mkv(1'b0, 8'h12, 8'h05, 8'ha7, 8'd0, 8'd4);
        tbl[0].exp_done = 8'd1;

        tbl[1] = mkv(1'b1, 8'h12, 8'h05, 8'h99, 8'd0, 8'd4);
        tbl[1].nr  = 3'd1;
        tbl[1].kb[0]  = 8'(40 + 16);
        tbl[1].pkt[0] = rsp_pkt(8'h12, 8'h05, 8'h3c, RD_OP, 1'b1, 1'b1);
        tbl[1].hit = 4'b0001;
        tbl[1].exp_n = 8'd1;
        tbl[1].exp_done = 8'd42;

        tbl[2] = mkv(1'b1, 8'hff, 8'h07, 8'h00, 8'd0, 8'd3);
        tbl[2].nr  = 3'd3;
        tbl[2].kb[0]  = 8'(3 + 16);
        tbl[2].pkt[0] = rsp_pkt(8'h01, 8'h07, 8'h11, RD_OP, 1'b1, 1'b1);
        tbl[2].kb[1]  = 8'(10 + 16);
        tbl[2].pkt[1] = rsp_pkt(8'h02, 8'h07, 8'h22, RD_OP, 1'b1, 1'b1);
        tbl[2].kb[2]  = 8'(T - 1 + 16);
        tbl[2].pkt[2] = rsp_pkt(8'h03, 8'h07, 8'h33, RD_OP, 1'b1, 1'b1);
        tbl[2].hit = 4'b0111;
        tbl[2].exp_n = 8'd3;
        tbl[2].exp_done = 8'(T + 1);

        tbl[3] = mkv(1'b1, 8'h20, 8'h09, 8'h00, 8'd0, 8'd2);
        tbl[3].nr  = 3'd1;
        tbl[3].kb[0]  = 8'(5 + 16);
        tbl[3].pkt[0] = rsp_pkt(8'h20, 8'h0a, 8'h55, RD_OP, 1'b1, 1'b1);
        tbl[3].exp_to = 1'b1;
        tbl[3].exp_done = 8'(T + 1);

        tbl[4] = mkv(1'b1, 8'h33, 8'h44, 8'h00, 8'd20, 8'd0);
        tbl[4].nr  = 3'd1;
        tbl[4].kb[0]  = 8'(T - 1 + 16);
        tbl[4].pkt[0] = rsp_pkt(8'h33, 8'h44, 8'h5a, RD_OP, 1'b1, 1'b1);
        tbl[4].hit = 4'b0001;
        tbl[4].exp_n = 8'd1;
        tbl[4].exp_done = 8'(T + 1);

        tbl[5] = mkv(1'b1, 8'hff, 8'h01, 8'h00, 8'd0, 8'd5);
        tbl[5].exp_to = 1'b1;
        tbl[5].exp_done = 8'(T + 1);

        tbl[6] = mkv(1'b1, 8'h40, 8'h02, 8'h00, 8'd0, 8'd3);
        tbl[6].abort_kb = 8'(10 + 16);

        tbl[7] = mkv(1'b1, 8'h41, 8'h03, 8'h00, 8'd0, 8'd2);
        tbl[7].nr  = 3'd2;
        tbl[7].kb[0]  = 8'(5 + 16);
        tbl[7].pkt[0] = rsp_pkt(8'h41, 8'h03, 8'hc1, RD_OP, 1'b1, 1'b0);
        tbl[7].kb[1]  = 8'(12 + 16);
        tbl[7].pkt[1] = rsp_pkt(8'h41, 8'h03, 8'hc2, RD_OP, 1'b1, 1'b1);
`ifdef CFG_PARITY_CHECK_EN
        tbl[7].hit = 4'b0011;
        tbl[7].exp_n = 8'd2;
        tbl[7].exp_done = 8'd14;
`else
        tbl[7].hit = 4'b0001;
        tbl[7].exp_n = 8'd1;
        tbl[7].exp_done = 8'd7;
`endif

        tbl[8] = mkv(1'b1, 8'h50, 8'h60, 8'h00, 8'd0, 8'd4);
        tbl[8].nr  = 3'd3;
        tbl[8].kb[0]  = 8'(2 + 16);
        tbl[8].pkt[0] = rsp_pkt(8'h50, 8'h60, 8'h01, RD_OP, 1'b0, 1'b1);
        tbl[8].kb[1]  = 8'(4 + 16);
        tbl[8].pkt[1] = rsp_pkt(8'h50, 8'h60, 8'h02, WR_OP, 1'b1, 1'b1);
        tbl[8].kb[2]  = 8'(6 + 16);
        tbl[8].pkt[2] = rsp_pkt(8'h50, 8'h60, 8'h03, RD_OP, 1'b1, 1'b1);
        tbl[8].hit = 4'b0100;
        tbl[8].exp_n = 8'd1;
        tbl[8].exp_done = 8'd8;

        tbl[9] = mkv(1'b1, 8'h70, 8'h71, 8'h00, 8'd0, 8'd6);
        tbl[9].nr  = 3'd1;
        tbl[9].kb[0]  = 8'(16 - 3);
        tbl[9].pkt[0] = rsp_pkt(8'h70, 8'h71, 8'h77, RD_OP, 1'b1, 1'b1);
        tbl[9].exp_to = 1'b1;
        tbl[9].exp_done = 8'(T + 1);

        reset_n      = 1'b0;
        cmd_valid    = 1'b0;
        cmd_read     = 1'b0;
        cmd_chip_id  = '0;
        cmd_addr     = '0;
        cmd_data     = '0;
        tx_busy      = 1'b0;
        rx_data      = '0;
        rx_data_flag = 1'b0;
        tick();
        tick();
        check_reset("reset");
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run(tbl[i], $sformatf("vec%0d", i));

        for (int r = 0; r < 30; r++) begin
            g  = $urandom_range(0, 3) == 0;
            rv = mkv($urandom_range(0, 3) != 0,
                     g ? 8'hff : 8'($urandom_range(0, 254)),
                     8'($urandom), 8'($urandom),
                     $urandom_range(0, 2) == 0 ? 8'($urandom_range(1, 10))
                                               : 8'd0,
                     $urandom_range(0, 4) == 0 ? 8'd0
                                               : 8'($urandom_range(2, 6)));
            k = -4 + int'($urandom_range(0, 8));
            n = 0;
            for (int i = 0; i < int'($urandom_range(0, 4)); i++) begin
                if (k > T + 2) break;
                c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : rv.chip;
                if (g && c == 8'hff) c = 8'($urandom_range(0, 254));
                a = ($urandom_range(0, 4) == 0) ? 8'($urandom) : rv.addr;
                rv.kb[i]  = 8'(k + 16);
                rv.pkt[i] = rsp_pkt(c, a, 8'($urandom),
                    $urandom_range(0, 9) == 0 ? WR_OP : RD_OP,
                    $urandom_range(0, 9) != 0,
                    $urandom_range(0, 4) != 0);
                n++;
                k = k + int'($urandom_range(1, 25));
            end
            rv.nr = 3'(n);
            rv = model(rv);
            run(rv, $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
